// File: rtl/multicycle_adder_pkg.sv
// Shared types and constants for the multicycle adder: slice width, FSM state
// encoding and the helper that turns an operand width into a slice count.
package multicycle_adder_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } AdderState;

   function automatic int nslice(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/multicycle_adder_seq_slice.sv
// The team's 4-bit ripple-carry slice; purely combinational, reused by the
// sequential adder once per cycle.
module ripple_carry_4Bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] carry;

   // Classic full-adder chain: each bit consumes the carry of the bit below.
   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      cout = carry[4];
   end

endmodule

// File: rtl/multicycle_adder_seq.sv
// Sequential WIDTH-bit adder that time-multiplexes one 4-bit ripple slice,
// with valid/ready on both sides. Optional ovf output: MULTICYCLE_ADDER_OVF_EN.
module multicycle_adder_seq
   import multicycle_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef MULTICYCLE_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSLICE = nslice(WIDTH);
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   // Reject widths that cannot be split into whole slices.
   if (WIDTH <= 0 || (WIDTH % SLICE_W) != 0) begin : gBadWidth
      $error("multicycle_adder_seq: WIDTH must be a positive multiple of 4");
   end

   AdderState          state;
   AdderState          stateNext;
   logic [WIDTH-1:0]   aReg;
   logic [WIDTH-1:0]   bReg;
   logic               carryReg;
   logic [IDX_W-1:0]   idx;
   logic [SLICE_W-1:0] sliceA;
   logic [SLICE_W-1:0] sliceB;
   logic [SLICE_W-1:0] sliceSum;
   logic               sliceCout;
   logic               accept;
   logic               lastSlice;
   logic               outFire;

   assign sliceA    = aReg[SLICE_W*idx +: SLICE_W];
   assign sliceB    = bReg[SLICE_W*idx +: SLICE_W];
   assign accept    = in_valid && in_ready;
   assign lastSlice = (state == BUSY) && (idx == LAST_IDX);
   assign outFire   = out_valid && out_ready;

   ripple_carry_4Bit uSlice (
      .a    (sliceA),
      .b    (sliceB),
      .cin  (carryReg),
      .sum  (sliceSum),
      .cout (sliceCout)
   );

   // State register; reset wins over any handshake on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic. Input side is only open in IDLE so a new operand pair
   // can never overlap a pending result.
   always_comb begin
      stateNext = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               stateNext = BUSY;
            end
         end
         BUSY: begin
            if (idx == LAST_IDX) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Datapath: capture operands on accept, then feed one slice per cycle,
   // writing its nibble of the result and carrying the carry forward.
   always_ff @(posedge clk) begin
      if (rst) begin
         aReg      <= '0;
         bReg      <= '0;
         carryReg  <= 1'b0;
         idx       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            aReg     <= a;
            bReg     <= b;
            carryReg <= cin;
            idx      <= '0;
         end
         if (state == BUSY) begin
            sum[SLICE_W*idx +: SLICE_W] <= sliceSum;
            carryReg                    <= sliceCout;
            if (lastSlice) begin
               idx       <= '0;
               cout      <= sliceCout;
               out_valid <= 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
         if (outFire) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef MULTICYCLE_ADDER_OVF_EN
   // Signed overflow: the carry into the top bit is recovered from the top
   // operand bits and the freshly computed top sum bit, then XORed with cout.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (lastSlice) begin
         ovf <= aReg[WIDTH-1] ^ bReg[WIDTH-1] ^ sliceSum[SLICE_W-1] ^ sliceCout;
      end else if (outFire) begin
         ovf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_adder_seq.sv
// Directed bench for multicycle_adder_seq with an arithmetic reference model
// and a per-cycle compare process. Exercises ovf when MULTICYCLE_ADDER_OVF_EN is set.
module tb_multicycle_adder_seq;

   localparam int WIDTH  = 16;
   localparam int NSLICE = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef MULTICYCLE_ADDER_OVF_EN
   logic             ovf;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      int               acceptCyc;
   } ExpEntry;

   ExpEntry expQ[$];
   bit      firstSeen = 1'b0;

   multicycle_adder_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef MULTICYCLE_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Free-running cycle counter used to measure latency.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference: plain unsigned addition for sum/cout, signed range test for ovf.
   function automatic ExpEntry model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                     input logic cv, input int when);
      ExpEntry e;
      logic [WIDTH:0] total;
      int sTotal;
      total  = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
      sTotal = int'($signed(av)) + int'($signed(bv)) + int'(cv);
      e.sum       = total[WIDTH-1:0];
      e.cout      = total[WIDTH];
      e.ovf       = (sTotal > 32767) || (sTotal < -32768);
      e.acceptCyc = when;
      return e;
   endfunction

   // Compare process: checks in_ready every cycle and the result every cycle
   // out_valid is high; a reset seen before the edge discards pending work.
   always @(negedge clk) begin
      if (rst) begin
         expQ.delete();
         firstSeen = 1'b0;
      end else begin
         checkOutput("in_ready", 32'(in_ready), 32'(expQ.size() == 0));
         if (out_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("out_valid_without_txn", 32'(out_valid), 32'd0);
            end else begin
               if (!firstSeen) begin
                  checkOutput("latency", 32'(cyc - expQ[0].acceptCyc), 32'(NSLICE + 1));
                  firstSeen = 1'b1;
               end
               checkOutput("model_sum", 32'(sum), 32'(expQ[0].sum));
               checkOutput("model_cout", 32'(cout), 32'(expQ[0].cout));
`ifdef MULTICYCLE_ADDER_OVF_EN
               checkOutput("model_ovf", 32'(ovf), 32'(expQ[0].ovf));
`endif
               if (out_ready) begin
                  void'(expQ.pop_front());
                  firstSeen = 1'b0;
               end
            end
         end
         if (in_valid && in_ready) begin
            expQ.push_back(model(a, b, cin, cyc));
         end
      end
   end

   // Presents one operand pair, waiting (bounded) for in_ready; returns #2
   // after the accepting edge.
   task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic cv);
      int guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk);
         #2;
         guard++;
      end
      checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
      a        = av;
      b        = bv;
      cin      = cv;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
   endtask

   // Waits for the result, pins it to hand-computed values, holds it for
   // 'hold' cycles of backpressure, then completes the output handshake.
   task automatic waitResult(input logic [WIDTH-1:0] expSum, input logic expCout,
                             input logic expOvf, input int hold);
      int guard = 0;
      while (!out_valid && guard < 20) begin
         @(posedge clk);
         #2;
         guard++;
      end
      checkOutput("result_timeout", 32'(out_valid), 32'd1);
      checkOutput("lit_sum", 32'(sum), 32'(expSum));
      checkOutput("lit_cout", 32'(cout), 32'(expCout));
`ifdef MULTICYCLE_ADDER_OVF_EN
      checkOutput("lit_ovf", 32'(ovf), 32'(expOvf));
`else
      if (expOvf) begin
         $display("[TB] note: signed overflow expected here, ovf port not built");
      end
`endif
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #2;
         checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_sum", 32'(sum), 32'(expSum));
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      out_ready = 1'b0;
      checkOutput("post_hs_out_valid", 32'(out_valid), 32'd0);
      checkOutput("post_hs_in_ready", 32'(in_ready), 32'd1);
   endtask

   // Directed scenarios.
   initial begin
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_sum", 32'(sum), 32'd0);
      checkOutput("reset_cout", 32'(cout), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

      applyStimulus(16'h1234, 16'h4321, 1'b0);
      waitResult(16'h5555, 1'b0, 1'b0, 0);

      applyStimulus(16'hFFFF, 16'h0001, 1'b0);
      waitResult(16'h0000, 1'b1, 1'b0, 0);

      applyStimulus(16'hFFFF, 16'h0000, 1'b1);
      waitResult(16'h0000, 1'b1, 1'b0, 0);

      applyStimulus(16'h00F0, 16'h0010, 1'b0);
      waitResult(16'h0100, 1'b0, 1'b0, 3);

      applyStimulus(16'h0001, 16'h0001, 1'b0);
      a        = 16'hAAAA;
      b        = 16'hAAAA;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      waitResult(16'h0002, 1'b0, 1'b0, 0);

      applyStimulus(16'h1111, 16'h2222, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midreset_sum", 32'(sum), 32'd0);
      checkOutput("midreset_cout", 32'(cout), 32'd0);
      checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(16'h0003, 16'h0004, 1'b0);
      waitResult(16'h0007, 1'b0, 1'b0, 0);

      applyStimulus(16'h7FFF, 16'h0001, 1'b0);
      waitResult(16'h8000, 1'b0, 1'b1, 0);

      applyStimulus(16'h8000, 16'h8000, 1'b0);
      waitResult(16'h0000, 1'b1, 1'b1, 1);

      applyStimulus(16'hFFFF, 16'h0001, 1'b0);
      waitResult(16'h0000, 1'b1, 1'b0, 0);

      repeat (3) @(posedge clk);
      #2;
      checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case the scenario sequence itself wedges.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
